gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__DFFRQ_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe.sv | 55 +++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe: DEPTH-stage enabled, clearable data pipeline with valid tags and occupancy count.
// Define GF180MCU_DFFRQ_PIPE_SCAN_EN to add a SE/SI/SO scan chain through every register.
module gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe #(
   parameter int               WIDTH  = 8,
   parameter int               DEPTH  = 2,
   parameter logic [WIDTH-1:0] RSTVAL = '0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         EN,
   input  logic                         CLR,
   input  logic [WIDTH-1:0]             D,
   input  logic                         DV,
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
   input  logic                         SE,
   input  logic                         SI,
   output logic                         SO,
`endif
   output logic [WIDTH-1:0]             Q,
   output logic                         QV,
   output logic [$clog2(DEPTH+1)-1:0]   OCC
);
   localparam int SW = DEPTH * WIDTH;
   localparam int OW = $clog2(DEPTH + 1);
   // Stage k data lives in s_q[k*WIDTH +: WIDTH]; stage 0 sits at the LSBs.
   logic [SW-1:0]    s_q, s_d;
   logic [DEPTH-1:0] v_q, v_d;
   logic [OW-1:0]    occ;
   always_comb begin
      s_d = CLR ? {DEPTH{RSTVAL}} : EN ? SW'({s_q, D}) : s_q;
      v_d = CLR ? '0 : EN ? DEPTH'({v_q, DV}) : v_q;
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
      if (SE) {v_d, s_d} = (SW + DEPTH)'({v_q, s_q, SI});
`endif
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_q <= {DEPTH{RSTVAL}};
         v_q <= '0;
      end else begin
         s_q <= s_d;
         v_q <= v_d;
      end
   end
   always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) occ = occ + OW'(v_q[k]);
   end
   assign Q   = s_q[SW-1 -: WIDTH];
   assign QV  = v_q[DEPTH-1];
   assign OCC = occ;
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
   assign SO  = v_q[DEPTH-1];
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe: directed vector table plus reset and scan sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, dv = 1'b0;
   logic [7:0] d = '0, q;
   logic       qv;
   logic [1:0] occ;
   int         n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
   logic       se = 1'b0, si = 1'b0, so, so_main;
   logic [3:0] sq;
   logic       sqv;
   logic [1:0] socc;
   logic [9:0] pat = 10'b1011001110;
   gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe #(.WIDTH(4), .DEPTH(2), .RSTVAL(4'h0)) u_scan (
      .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .D(d[3:0]), .DV(dv),
      .SE(se), .SI(si), .SO(so), .Q(sq), .QV(sqv), .OCC(socc));
`endif
   gf180mcu_fd_sc_mcu9t5v0__dffrq_pipe #(.WIDTH(8), .DEPTH(3), .RSTVAL(8'hA5)) u_dut (
      .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .D(d), .DV(dv),
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
      .SE(1'b0), .SI(1'b0), .SO(so_main),
`endif
      .Q(q), .QV(qv), .OCC(occ));
   typedef struct {
      logic       en, clr;
      logic [7:0] d;
      logic       dv;
      logic [7:0] q;
      logic       qv;
      logic [1:0] occ;
   } vec_t;
   vec_t tv[17];
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [7:0] eq, input logic eqv, input logic [1:0] eocc);
      chk({tag, ".Q"}, 64'(q), 64'(eq));
      chk({tag, ".QV"}, 64'(qv), 64'(eqv));
      chk({tag, ".OCC"}, 64'(occ), 64'(eocc));
   endtask
   initial begin
      tv[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'hA5, 1'b0, 2'd1};
      tv[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 8'hA5, 1'b0, 2'd2};
      tv[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h11, 1'b1, 2'd3};
      tv[3]  = '{1'b0, 1'b1, 8'h44, 1'b1, 8'hA5, 1'b0, 2'd0};
      tv[4]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'hA5, 1'b0, 2'd1};
      tv[5]  = '{1'b0, 1'b0, 8'h99, 1'b1, 8'hA5, 1'b0, 2'd1};
      tv[6]  = '{1'b0, 1'b0, 8'h98, 1'b0, 8'hA5, 1'b0, 2'd1};
      tv[7]  = '{1'b1, 1'b0, 8'h22, 1'b1, 8'hA5, 1'b0, 2'd2};
      tv[8]  = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h11, 1'b1, 2'd3};
      tv[9]  = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h22, 1'b1, 2'd3};
      tv[10] = '{1'b1, 1'b1, 8'h55, 1'b1, 8'hA5, 1'b0, 2'd0};
      tv[11] = '{1'b1, 1'b0, 8'h01, 1'b1, 8'hA5, 1'b0, 2'd1};
      tv[12] = '{1'b1, 1'b0, 8'h02, 1'b0, 8'hA5, 1'b0, 2'd1};
      tv[13] = '{1'b1, 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 2'd2};
      tv[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 2'd1};
      tv[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 2'd1};
      tv[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
      #12;
      chk_out("reset", 8'hA5, 1'b0, 2'd0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         en = tv[i].en; clr = tv[i].clr; d = tv[i].d; dv = tv[i].dv;
         @(posedge clk); #1;
         chk_out($sformatf("vec%0d", i), tv[i].q, tv[i].qv, tv[i].occ);
      end
      // Refill, then reset asynchronously between edges and hold it across an edge.
      en = 1'b1; clr = 1'b0; dv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = 8'(8'h60 + i);
         @(posedge clk); #1;
      end
      chk_out("refill", 8'h60, 1'b1, 2'd3);
      #2 rst = 1'b1;
      #1 chk_out("async_rst", 8'hA5, 1'b0, 2'd0);
      d = 8'h66;
      @(posedge clk); #1;
      chk_out("rst_edge", 8'hA5, 1'b0, 2'd0);
      #2 rst = 1'b0;
      d = 8'h77; dv = 1'b1;
      @(posedge clk); #1;
      chk_out("post_rst1", 8'hA5, 1'b0, 2'd1);
      d = 8'h00; dv = 1'b0;
      @(posedge clk); #1;
      chk_out("post_rst2", 8'hA5, 1'b0, 2'd1);
      @(posedge clk); #1;
      chk_out("post_rst3", 8'h77, 1'b1, 2'd1);
`ifdef GF180MCU_DFFRQ_PIPE_SCAN_EN
      for (int e = 0; e < 19; e++) begin
         se = 1'b1;
         si = (e < 10) ? pat[9-e] : 1'b0;
         en = 1'($urandom);
         clr = 1'($urandom);
         @(posedge clk); #1;
         if (e >= 9) chk($sformatf("scan_so%0d", e - 9), 64'(so), 64'(pat[18-e]));
      end
      se = 1'b0;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
